// File: rtl/calc_sequencer_if.sv
// Bank-side bus of the calc_sequencer: write strobes, addresses and write data
// toward the 16x8 data/instruction banks, plus their registered read data.
interface calc_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              data_we;
  logic              inst_we;
  logic [ADDR_W-1:0] data_addr;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] inst_in;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] inst_out;

  modport master (
    output data_we, inst_we, data_addr, inst_addr, data_in, inst_in,
    input  data_out, inst_out
  );

  modport slave (
    input  data_we, inst_we, data_addr, inst_addr, data_in, inst_in,
    output data_out, inst_out
  );
endinterface

// File: rtl/calc_sequencer.sv
// Accumulator program sequencer: passes host loads to the banks while idle,
// and on start runs the stored program until HALT or the step limit.
module calc_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int MAX_STEPS = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              host_data_we,
  input  logic              host_inst_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  calc_sequencer_if.master  mem,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              carry
);

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, DONE} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              carry_reg, carry_next;
  logic              error_reg, error_next;
  logic [7:0]        step_reg, step_next;
  logic [3:0]        ir_op_reg, ir_op_next;

  logic [3:0]        dec_op;
  logic [ADDR_W-1:0] dec_a;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  assign dec_op = mem.inst_out[DATA_W-1:DATA_W-4];
  assign dec_a  = mem.inst_out[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      pc_reg    <= '0;
      carry_reg <= 1'b0;
      error_reg <= 1'b0;
      step_reg  <= '0;
      ir_op_reg <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      pc_reg    <= pc_next;
      carry_reg <= carry_next;
      error_reg <= error_next;
      step_reg  <= step_next;
      ir_op_reg <= ir_op_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    pc_next       = pc_reg;
    carry_next    = carry_reg;
    error_next    = error_reg;
    step_next     = step_reg;
    ir_op_next    = ir_op_reg;
    sum           = {1'b0, acc_reg} + {1'b0, mem.data_out};
    diff          = {1'b0, acc_reg} - {1'b0, mem.data_out};
    mem.data_we   = 1'b0;
    mem.inst_we   = 1'b0;
    mem.data_addr = '0;
    mem.inst_addr = '0;
    mem.data_in   = '0;
    mem.inst_in   = '0;

    case (state_reg)
      IDLE, DONE: begin
        // Host owns the banks; data write takes priority like the bank does.
        mem.data_we   = host_data_we;
        mem.inst_we   = host_inst_we & ~host_data_we;
        mem.data_addr = host_addr;
        mem.inst_addr = host_addr;
        mem.data_in   = host_wdata;
        mem.inst_in   = host_wdata;
        if (start) begin
          pc_next    = '0;
          acc_next   = '0;
          carry_next = 1'b0;
          error_next = 1'b0;
          step_next  = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        mem.inst_addr = pc_reg;
        state_next    = DECODE;
      end
      DECODE: begin
        ir_op_next = dec_op;
        step_next  = step_reg + 8'd1;
        if (step_next == 8'(MAX_STEPS) && dec_op != OP_HALT) begin
          error_next = 1'b1;
          state_next = DONE;
        end else begin
          case (dec_op)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              mem.data_addr = dec_a;
              state_next    = EXEC;
            end
            OP_STORE: begin
              mem.data_we   = 1'b1;
              mem.data_addr = dec_a;
              mem.data_in   = acc_reg;
              pc_next       = pc_reg + 1'b1;
              state_next    = FETCH;
            end
            OP_JZ: begin
              pc_next    = (acc_reg == '0) ? dec_a : pc_reg + 1'b1;
              state_next = FETCH;
            end
            OP_JMP: begin
              pc_next    = dec_a;
              state_next = FETCH;
            end
            OP_HALT: state_next = DONE;
            default: begin
              pc_next    = pc_reg + 1'b1;
              state_next = FETCH;
            end
          endcase
        end
      end
      EXEC: begin
        case (ir_op_reg)
          OP_LOAD: acc_next = mem.data_out;
          OP_ADD: begin
            acc_next   = sum[DATA_W-1:0];
            carry_next = sum[DATA_W];
          end
          OP_SUB: begin
            acc_next   = diff[DATA_W-1:0];
            carry_next = diff[DATA_W];
          end
          OP_AND:  acc_next = acc_reg & mem.data_out;
          OP_OR:   acc_next = acc_reg | mem.data_out;
          OP_XOR:  acc_next = acc_reg ^ mem.data_out;
          default: acc_next = acc_reg;
        endcase
        pc_next    = pc_reg + 1'b1;
        state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase

    // Bank strobes must drop the moment reset asserts, not at the next edge.
    if (!rst) begin
      mem.data_we   = 1'b0;
      mem.inst_we   = 1'b0;
      mem.data_addr = '0;
      mem.inst_addr = '0;
      mem.data_in   = '0;
      mem.inst_in   = '0;
    end
  end

  assign busy  = (state_reg == FETCH) || (state_reg == DECODE) || (state_reg == EXEC);
  assign done  = (state_reg == DONE);
  assign error = error_reg;
  assign acc   = acc_reg;
  assign pc    = pc_reg;
  assign carry = carry_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: behavioural 16x8 bank pair, host loads, program
// runs scored through an expected-result queue.
module tb_calc_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       host_data_we;
  logic       host_inst_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] acc;
  logic [3:0] pc;
  logic       carry;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] acc;
    logic       carry;
    logic [3:0] pc;
    logic       err;
    int         cycles;
  } exp_t;

  exp_t sb[$];

  calc_sequencer_if #(.DATA_W(8), .ADDR_W(4)) mem_bus ();

  calc_sequencer #(.DATA_W(8), .ADDR_W(4), .MAX_STEPS(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .host_data_we (host_data_we),
    .host_inst_we (host_inst_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .mem          (mem_bus),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .acc          (acc),
    .pc           (pc),
    .carry        (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: registered reads, data write has priority over inst write.
  logic [7:0] dmem [16];
  logic [7:0] imem [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      dmem[i] = 8'h00;
      imem[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    if (mem_bus.data_we) dmem[mem_bus.data_addr] <= mem_bus.data_in;
    else if (mem_bus.inst_we) imem[mem_bus.inst_addr] <= mem_bus.inst_in;
    mem_bus.data_out <= dmem[mem_bus.data_addr];
    mem_bus.inst_out <= imem[mem_bus.inst_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input bit is_inst, input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    host_data_we = !is_inst;
    host_inst_we = is_inst;
    host_addr    = addr;
    host_wdata   = data;
    @(posedge clk);
    #1;
    host_data_we = 1'b0;
    host_inst_we = 1'b0;
  endtask

  task automatic run_prog(input string tag, input logic [7:0] e_acc, input logic e_carry,
                          input logic [3:0] e_pc, input logic e_err, input int e_cyc,
                          input bit hammer);
    exp_t e;
    int   n;
    int   viol;
    bit   ok;
    e.tag = tag; e.acc = e_acc; e.carry = e_carry; e.pc = e_pc; e.err = e_err; e.cycles = e_cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0; viol = 0; ok = 1'b0;
    if (hammer) begin
      host_data_we = 1'b1;
      host_addr    = 4'd5;
      host_wdata   = 8'hEE;
      #1;
      if (busy && mem_bus.data_we) viol++;
    end
    while (n < 1000 && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (hammer && busy && mem_bus.data_we) viol++;
      if (done) ok = 1'b1;
    end
    host_data_we = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_done"}, ok, 1);
    check({e.tag, "_cycles"}, n, e.cycles);
    check({e.tag, "_acc"}, acc, e.acc);
    check({e.tag, "_carry"}, carry, e.carry);
    check({e.tag, "_pc"}, pc, e.pc);
    check({e.tag, "_error"}, error, e.err);
    check({e.tag, "_busy"}, busy, 0);
    if (hammer) check({e.tag, "_host_we_leak"}, viol, 0);
    $display("run %s: cycles=%0d acc=%02h carry=%0d pc=%0d error=%0d", e.tag, n, acc, carry, pc, error);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    host_data_we = 1'b0;
    host_inst_we = 1'b0;
    host_addr = 4'd0;
    host_wdata = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_acc", acc, 0);
    check("rst_pc", pc, 0);
    check("rst_carry", carry, 0);
    check("rst_mem_we", {mem_bus.data_we, mem_bus.inst_we}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic load / add / store.
    host_write(0, 4'd3, 8'h05);
    host_write(0, 4'd4, 8'h07);
    host_write(1, 4'd0, 8'h03);
    host_write(1, 4'd1, 8'h24);
    host_write(1, 4'd2, 8'h15);
    host_write(1, 4'd3, 8'hF0);
    run_prog("basic", 8'h0C, 1'b0, 4'd3, 1'b0, 10, 1'b0);
    check("basic_d5", dmem[5], 8'h0C);

    // Carry out of ADD and borrow out of SUB.
    host_write(0, 4'd0, 8'hF0);
    host_write(0, 4'd1, 8'h20);
    host_write(1, 4'd0, 8'h00);
    host_write(1, 4'd1, 8'h21);
    host_write(1, 4'd2, 8'hF0);
    run_prog("add_carry", 8'h10, 1'b1, 4'd2, 1'b0, 8, 1'b0);
    host_write(1, 4'd0, 8'h01);
    host_write(1, 4'd1, 8'h30);
    run_prog("sub_borrow", 8'h30, 1'b1, 4'd2, 1'b0, 8, 1'b0);

    // JZ taken and not taken.
    host_write(0, 4'd0, 8'h00);
    host_write(1, 4'd0, 8'h00);
    host_write(1, 4'd1, 8'h76);
    host_write(1, 4'd2, 8'hF0);
    host_write(1, 4'd6, 8'hF0);
    run_prog("jz_taken", 8'h00, 1'b0, 4'd6, 1'b0, 7, 1'b0);
    host_write(0, 4'd0, 8'h11);
    run_prog("jz_fall", 8'h11, 1'b0, 4'd2, 1'b0, 7, 1'b0);

    // Logic ops then STORE.
    host_write(0, 4'd0, 8'hF0);
    host_write(0, 4'd1, 8'h3C);
    host_write(1, 4'd0, 8'h00);
    host_write(1, 4'd1, 8'h41);
    host_write(1, 4'd2, 8'h51);
    host_write(1, 4'd3, 8'h60);
    host_write(1, 4'd4, 8'h17);
    host_write(1, 4'd5, 8'hF0);
    run_prog("logic", 8'hCC, 1'b0, 4'd5, 1'b0, 16, 1'b0);
    check("logic_d7", dmem[7], 8'hCC);

    // Step-limit abort on a tight JMP loop.
    host_write(1, 4'd0, 8'h80);
    run_prog("step_limit", 8'h00, 1'b0, 4'd0, 1'b1, 510, 1'b0);

    // Simultaneous host writes: data wins, inst dropped.
    @(negedge clk);
    host_data_we = 1'b1;
    host_inst_we = 1'b1;
    host_addr    = 4'd9;
    host_wdata   = 8'h77;
    #1;
    check("both_we_inst", mem_bus.inst_we, 0);
    check("both_we_data", mem_bus.data_we, 1);
    @(posedge clk);
    #1;
    host_data_we = 1'b0;
    host_inst_we = 1'b0;
    check("both_we_d9", dmem[9], 8'h77);
    check("both_we_i9", imem[9], 8'h00);

    // Host writes to D5 while running must be dropped.
    host_write(0, 4'd5, 8'h5A);
    host_write(0, 4'd3, 8'h05);
    host_write(1, 4'd0, 8'h03);
    host_write(1, 4'd1, 8'h23);
    host_write(1, 4'd2, 8'hF0);
    run_prog("host_drop", 8'h0A, 1'b0, 4'd2, 1'b0, 8, 1'b1);
    check("host_drop_d5", dmem[5], 8'h5A);

    // Async reset during EXEC of the ADD, then a clean rerun.
    host_write(0, 4'd4, 8'h07);
    host_write(1, 4'd0, 8'h03);
    host_write(1, 4'd1, 8'h24);
    host_write(1, 4'd2, 8'h15);
    host_write(1, 4'd3, 8'hF0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_acc", acc, 8'h05);
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_acc", acc, 0);
    check("arst_pc", pc, 0);
    check("arst_mem_we", {mem_bus.data_we, mem_bus.inst_we}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", {busy, done, error}, 0);
    run_prog("after_reset", 8'h0C, 1'b0, 4'd3, 1'b0, 10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
